inv_mixcolumns_iter: RTL and testbench
======================================

// Module: inv_mixcolumns_iter
// PURPOSE
//  AES InvMixColumns for the decryption datapath; the inverse of the forward mixcolumns stage.
//  Accepts a 128-bit state over a valid/ready handshake.
//  Default build transforms one 32-bit column per clock, four columns in all.
//  Holds the result until the downstream stage takes it. Sits between InvShiftRows/InvSubBytes and AddRoundKey.
// PARAMETERS
//  NCOL     4    columns per state; fixed at 4, exposed only for the 4*32 width checks
//  CNT_W    2    column counter width
// PORTS
//  clk        in   1    rising-edge clock, single domain
//  rst_n      in   1    synchronous reset, active-low
//  in_valid   in   1    data_in holds a valid state
//  in_ready   out  1    block can accept a state
//  data_in    in   128  input state; column c = [32c+31:32c], row r of column = [8r+7:8r]
//  out_valid  out  1    data_out holds a finished state
//  out_ready  in   1    downstream accepts data_out
//  data_out   out  128  InvMixColumns(data_in), same byte layout
// BEHAVIOUR
//  - Reset: rst_n sampled low at a clk edge -> IDLE, cnt=0, state reg=0.
//    Gives out_valid=0 and data_out=0; in_ready=1 from the first edge after release.
//    Reset mid-BUSY or in DONE discards the block silently.
//  - Per column a0..a3 (row 0..3), over GF(2^8) with poly 0x11B:
//    b0=0e*a0^0b*a1^0d*a2^09*a3   b1=09*a0^0e*a1^0b*a2^0d*a3
//    b2=0d*a0^09*a1^0e*a2^0b*a3   b3=0b*a0^0d*a1^09*a2^0e*a3
//  - FSM states IDLE, BUSY, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
//  - IDLE: in_valid&in_ready at edge E0 -> latch data_in, cnt=0, go to BUSY. in_valid low -> stay.
//  - BUSY: each edge overwrites column cnt with its transform, then cnt++.
//    The edge that processes cnt==3 moves to DONE; cnt wraps to 0.
//    in_valid is ignored while BUSY.
//  - DONE: data_out = state reg, held stable while out_ready=0.
//    out_valid&out_ready at an edge -> IDLE. No new accept on that same edge.
//  - Latency: handshake at E0 -> out_valid high after E4. Throughput: 1 state per 6 cycles at best.
//  - data_out is visible in every state but only meaningful while out_valid=1.
//  - Back-pressure: out_ready=0 indefinitely keeps DONE; in_ready stays 0.
// CONFIGURATION
//  INV_MIXCOL_PARALLEL_EN defined:
//    - four inv_mix_word instances.
//    - The accept edge latches all four transformed columns and goes straight IDLE->DONE.
//    - Latency: handshake at E0 -> out_valid high after E0. BUSY is never entered; cnt stays 0.
//  Undefined (default):
//    - one shared inv_mix_word, muxed by cnt; iterative timing as above.
//  Port list and handshake rules are identical in both builds.
// STRUCTURE
//  aes_pkg:
//    - xtime function: shift left, XOR 0x1B when msb set.
//    - gmul09/0b/0d/0e functions built from xtime.
//    - FSM state encoding constants IDLE/BUSY/DONE.
//    - AES_STATE_W=128 and AES_COL_W=32.
//  Sub-module inv_mix_word:
//    - combinational, 32-bit in / 32-bit out; one column per the equations above.
//    - Reused by both builds.
//  Top level holds: FSM, cnt, 128-bit state register, column write-back mux.
// TESTING
//  1 FIPS-197 single column:
//    data_in col0=32'hbca14d8e, other cols 0 -> data_out col0=32'h455313db, others 0.
//  2 Full state:
//    data_in={32'h01010101,32'hc6c6c6c6,32'h9d58dc9f,32'hd6d7d5d5}
//    -> data_out={32'h01010101,32'hc6c6c6c6,32'h5c220af2,32'hd5d4d4d4}.
//    out_valid after E4 (after E0 when INV_MIXCOL_PARALLEL_EN).
//  3 Back-pressure:
//    - hold out_ready=0 for 10 cycles in DONE -> data_out stable, in_ready=0.
//    - in_valid pulses ignored.
//    - out_ready=1 -> IDLE next edge.
//  4 Reset mid-BUSY:
//    - rst_n=0 on the edge where cnt==2 -> out_valid=0, data_out=0.
//    - Next accepted block (test 1 vector) gives the correct result.
//  5 Round trip:
//    - 1000 random states through a forward MixColumns model into this block -> output equals original.
//    - Randomise in_valid/out_ready gaps; no lost or duplicated blocks.
//  6 Zero/ones:
//    - 128'h0 -> 128'h0.
//    - 128'hffff...ff -> 128'hffff...ff (column coefficients XOR to 01).

Source files
------------

// File: rtl/aes_pkg.sv
// AES helpers shared by the InvMixColumns datapath: widths, FSM encoding, GF(2^8) multiplies.
package aes_pkg;

    localparam int unsigned AES_STATE_W = 128;
    localparam int unsigned AES_COL_W   = 32;
    localparam int unsigned AES_BYTE_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mix_state_t;

    // Multiply by x (0x02) modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul09(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] gmul0b(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] gmul0d(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] gmul0e(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/inv_mix_word.sv
// Combinational InvMixColumns of one 32-bit column; row r lives in bits [8r+7:8r].
module inv_mix_word
    import aes_pkg::*;
(
    input  logic [AES_COL_W-1:0] col,
    output logic [AES_COL_W-1:0] mixed_c
);

    logic [AES_BYTE_W-1:0] a0, a1, a2, a3;

    // Circulant matrix {0e,0b,0d,09} applied to the column bytes
    always_comb begin
        a0 = col[7:0];
        a1 = col[15:8];
        a2 = col[23:16];
        a3 = col[31:24];
        mixed_c[7:0]   = gmul0e(a0) ^ gmul0b(a1) ^ gmul0d(a2) ^ gmul09(a3);
        mixed_c[15:8]  = gmul09(a0) ^ gmul0e(a1) ^ gmul0b(a2) ^ gmul0d(a3);
        mixed_c[23:16] = gmul0d(a0) ^ gmul09(a1) ^ gmul0e(a2) ^ gmul0b(a3);
        mixed_c[31:24] = gmul0b(a0) ^ gmul0d(a1) ^ gmul09(a2) ^ gmul0e(a3);
    end

endmodule

// File: rtl/inv_mixcolumns_iter.sv
// AES InvMixColumns stage with valid/ready on both sides.
// Default build: one column per clock through a shared inv_mix_word (4 cycles per state).
// INV_MIXCOL_PARALLEL_EN: four inv_mix_word instances, whole state on the accept edge.
module inv_mixcolumns_iter
    import aes_pkg::*;
#(
    parameter int unsigned NCOL  = 4,
    parameter int unsigned CNT_W = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] data_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] data_out
);

    mix_state_t             fsm;
    logic [AES_STATE_W-1:0] state_q;

    assign data_out = state_q;

`ifdef INV_MIXCOL_PARALLEL_EN

    logic [AES_STATE_W-1:0] mixed_all_c;

    // One transform per column so the full state is ready in the accept cycle
    for (genvar g = 0; g < NCOL; g++) begin : g_col
        inv_mix_word u_word (
            .col     (data_in[g*AES_COL_W +: AES_COL_W]),
            .mixed_c (mixed_all_c[g*AES_COL_W +: AES_COL_W])
        );
    end

    // Handshake FSM: accept straight into DONE, hold until taken
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm       <= IDLE;
            state_q   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        state_q   <= mixed_all_c;
                        fsm       <= DONE;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        fsm       <= IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    fsm       <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`else

    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(NCOL - 1);

    logic [CNT_W-1:0]     cnt;
    logic [AES_COL_W-1:0] col_sel;
    logic [AES_COL_W-1:0] col_mixed_c;

    // Column currently being transformed, picked out of the state register
    assign col_sel = state_q[AES_COL_W*cnt +: AES_COL_W];

    inv_mix_word u_word (
        .col     (col_sel),
        .mixed_c (col_mixed_c)
    );

    // Handshake FSM: latch state, write back one column per BUSY edge, hold result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm       <= IDLE;
            cnt       <= '0;
            state_q   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        state_q  <= data_in;
                        cnt      <= '0;
                        fsm      <= BUSY;
                        in_ready <= 1'b0;
                    end
                end
                BUSY: begin
                    state_q[AES_COL_W*cnt +: AES_COL_W] <= col_mixed_c;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_COL) begin
                        fsm       <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        fsm       <= IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    fsm       <= IDLE;
                    cnt       <= '0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_inv_mixcolumns_iter.sv
// Self-checking bench for inv_mixcolumns_iter (both builds; INV_MIXCOL_PARALLEL_EN selects latency).
module tb_inv_mixcolumns_iter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] data_in = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] data_out;

    int checks = 0;
    int failures = 0;

`ifdef INV_MIXCOL_PARALLEL_EN
    localparam int EXP_LAT = 0;
`else
    localparam int EXP_LAT = 4;
`endif

    always #5 clk = ~clk;

    inv_mixcolumns_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out)
    );

    typedef struct {
        string        name;
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    vec_t         vecs[6];
    logic [127:0] exp_q[$];

    // Forward MixColumns reference used to build round-trip stimulus
    function automatic logic [7:0] tb_xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] fwd_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3;
        a0 = c[7:0]; a1 = c[15:8]; a2 = c[23:16]; a3 = c[31:24];
        b0 = tb_xt(a0) ^ tb_xt(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ tb_xt(a1) ^ tb_xt(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ tb_xt(a2) ^ tb_xt(a3) ^ a3;
        b3 = tb_xt(a0) ^ a0 ^ a1 ^ a2 ^ tb_xt(a3);
        return {b3, b2, b1, b0};
    endfunction

    function automatic logic [127:0] fwd_state(input logic [127:0] s);
        return {fwd_col(s[127:96]), fwd_col(s[95:64]), fwd_col(s[63:32]), fwd_col(s[31:0])};
    endfunction

    task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push one state in, wait for the result; leaves the block in DONE
    task automatic run_block(input logic [127:0] din, output logic [127:0] dout, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        check_int("in_ready_before_accept", int'(in_ready), 1);
        data_in  = din;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        dout = data_out;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [127:0] res;
        int           lat;

        vecs[0] = '{"fips_col0",  128'h00000000_00000000_00000000_bca14d8e,
                                  128'h00000000_00000000_00000000_455313db};
        vecs[1] = '{"full_state", {32'h01010101, 32'hc6c6c6c6, 32'h9d58dc9f, 32'hd6d7d5d5},
                                  {32'h01010101, 32'hc6c6c6c6, 32'h5c220af2, 32'hd5d4d4d4}};
        vecs[2] = '{"zeros",      128'h0, 128'h0};
        vecs[3] = '{"ones",       {128{1'b1}}, {128{1'b1}}};
        vecs[4] = '{"fips_col3",  128'hbca14d8e_00000000_00000000_00000000,
                                  128'h455313db_00000000_00000000_00000000};
        vecs[5] = '{"mixed_cols", {32'hd6d7d5d5, 32'h9d58dc9f, 32'hbca14d8e, 32'h01010101},
                                  {32'hd5d4d4d4, 32'h5c220af2, 32'h455313db, 32'h01010101}};

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        check_int("rst_out_valid", int'(out_valid), 0);
        check128("rst_data_out", data_out, 128'h0);
        rst_n = 1'b1;
        tick();
        check_int("rst_in_ready", int'(in_ready), 1);

        // Directed vectors
        for (int i = 0; i < 6; i++) begin
            run_block(vecs[i].din, res, lat);
            check128(vecs[i].name, res, vecs[i].dout);
            check_int({vecs[i].name, "_latency"}, lat, EXP_LAT);
            consume();
            check_int({vecs[i].name, "_released"}, int'(out_valid), 0);
            check_int({vecs[i].name, "_ready_again"}, int'(in_ready), 1);
        end

        // Back-pressure: result held, new requests ignored
        run_block(vecs[1].din, res, lat);
        for (int i = 0; i < 10; i++) begin
            in_valid = ((i % 2) == 0);
            data_in  = {$urandom(), $urandom(), $urandom(), $urandom()};
            tick();
            check128("bp_data_stable", data_out, vecs[1].dout);
            check_int("bp_in_ready", int'(in_ready), 0);
            check_int("bp_out_valid", int'(out_valid), 1);
        end
        in_valid  = 1'b1;
        data_in   = 128'h0;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_int("bp_release_out_valid", int'(out_valid), 0);
        check_int("bp_release_in_ready", int'(in_ready), 1);
        tick();
        check_int("bp_no_same_edge_accept", int'(in_ready), 1);
        check_int("bp_no_same_edge_valid", int'(out_valid), 0);

        // Reset asserted on the edge that would process column 2
        data_in  = vecs[1].din;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check_int("midrst_out_valid", int'(out_valid), 0);
        check128("midrst_data_out", data_out, 128'h0);
        rst_n = 1'b1;
        tick();
        run_block(vecs[0].din, res, lat);
        check128("midrst_next_block", res, vecs[0].dout);
        check_int("midrst_next_latency", lat, EXP_LAT);
        consume();

        // Round trip with random gaps on both sides
        fork
            begin
                logic [127:0] orig;
                int           g;
                bit           rdy;
                for (int i = 0; i < 1000; i++) begin
                    orig = {$urandom(), $urandom(), $urandom(), $urandom()};
                    exp_q.push_back(orig);
                    repeat ($urandom_range(0, 3)) tick();
                    data_in  = fwd_state(orig);
                    in_valid = 1'b1;
                    g = 0;
                    do begin
                        rdy = in_ready;
                        tick();
                        g++;
                    end while (!rdy && g < 100);
                    in_valid = 1'b0;
                    if (!rdy) begin
                        failures++;
                        $display("FAIL rt_accept_timeout: block %0d not accepted", i);
                        break;
                    end
                end
            end
            begin
                logic [127:0] e;
                int           got;
                int           cyc;
                got = 0;
                cyc = 0;
                while (got < 1000 && cyc < 40000) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            failures++;
                            $display("FAIL rt_duplicate: output with no block pending at %0d", got);
                        end else begin
                            e = exp_q.pop_front();
                            check128("roundtrip", data_out, e);
                        end
                        got++;
                    end
                    tick();
                    cyc++;
                end
                out_ready = 1'b0;
                if (got < 1000) begin
                    failures++;
                    $display("FAIL rt_output_timeout: got %0d blocks expected 1000", got);
                end
            end
        join
        check_int("rt_none_lost", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
